// File: rtl/rle_pkg.sv
// Shared types for the RLE stream packer: pair layout and serialiser phase.
package rle_pkg;

  localparam int DATA_W_DEF = 8;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] value;
    logic        [DATA_W_DEF-1:0] count;
  } pair_t;

  typedef enum logic {
    VALUE = 1'b0,
    COUNT = 1'b1
  } phase_e;

endpackage

// File: rtl/rle_pair_fifo.sv
// Dual-push, single-pop circular buffer of {value, count} pairs.
module rle_pair_fifo #(
  parameter int DEPTH  = 16,
  parameter int PAIR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push1,
  input  logic                     push2,
  input  logic [PAIR_W-1:0]        din1,
  input  logic [PAIR_W-1:0]        din2,
  input  logic                     pop,
  output logic [PAIR_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PAIR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr2;

  // Lane 2 lands behind lane 1 only when both push this cycle.
  assign wr_ptr2 = push1 ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push1) mem[wr_ptr]  <= din1;
    if (push2) mem[wr_ptr2] <= din2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push1) + PTR_W'(push2);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      level  <= level + LVL_W'(push1) + LVL_W'(push2) - LVL_W'(pop);
    end
  end

endmodule

// File: rtl/rle_stream_packer.sv
// Buffers two RLE lanes and serialises each pair as a value byte then a count byte.
module rle_stream_packer
  import rle_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid1,
  input  logic [DATA_W-1:0]      value1,
  input  logic [DATA_W-1:0]      count1,
  input  logic                   in_valid2,
  input  logic [DATA_W-1:0]      value2,
  input  logic [DATA_W-1:0]      count2,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int PAIR_W = 2 * DATA_W;

  phase_e            phase, phase_nxt;
  logic              push1, push2, pop;
  logic [PAIR_W-1:0] head;

  // Free space is judged on the registered level only; a same-cycle pop does not help.
  assign in_ready = (level <= LVL_W'(DEPTH - 2));
  assign push1    = in_valid1 & in_ready;
  assign push2    = in_valid2 & in_ready;

  rle_pair_fifo #(.DEPTH(DEPTH), .PAIR_W(PAIR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push1 (push1),
    .push2 (push2),
    .din1  ({value1, count1}),
    .din2  ({value2, count2}),
    .pop   (pop),
    .head  (head),
    .level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      phase    <= VALUE;
    end else begin
      if ((in_valid1 | in_valid2) & ~in_ready) overflow <= 1'b1;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    out_valid = 1'b0;
    out_data  = '0;
    pop       = 1'b0;
    case (phase)
      VALUE: begin
        out_valid = (level != '0);
        if (out_valid) begin
          out_data = head[PAIR_W-1:DATA_W];
          if (out_ready) phase_nxt = COUNT;
        end
      end
      COUNT: begin
        out_valid = 1'b1;
        out_data  = head[DATA_W-1:0];
        if (out_ready) begin
          pop       = 1'b1;
          phase_nxt = VALUE;
        end
      end
      default: phase_nxt = VALUE;
    endcase
  end

endmodule

// File: tb/tb_rle_stream_packer.sv
// Scoreboard bench for rle_stream_packer: expected bytes queued at drive, checked at handshake.
module tb_rle_stream_packer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid1, in_valid2, out_ready;
  logic [DATA_W-1:0] value1, count1, value2, count2;
  logic              in_ready, out_valid, overflow;
  logic [DATA_W-1:0] out_data;
  logic [$clog2(DEPTH):0] level;

  int n_checks = 0;
  int n_fail   = 0;
  int byte_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  rle_stream_packer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid1(in_valid1), .value1(value1), .count1(count1),
    .in_valid2(in_valid2), .value2(value2), .count2(count2),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable between posedge+1 and the next posedge, so a handshake seen here is taken.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      byte_cnt++;
      if (exp_q.size() == 0) check("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
      else                   check("byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // Called at posedge+1; drives one cycle of lanes and returns at the next posedge+1.
  task automatic drive(input bit a, input logic [7:0] v1, c1,
                       input bit b, input logic [7:0] v2, c2);
    in_valid1 = a; value1 = v1; count1 = c1;
    in_valid2 = b; value2 = v2; count2 = c2;
    if (a) begin exp_q.push_back(v1); exp_q.push_back(c1); end
    if (b) begin exp_q.push_back(v2); exp_q.push_back(c2); end
    @(posedge clk); #1;
    in_valid1 = 0; in_valid2 = 0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int start;
    rst = 1; in_valid1 = 0; in_valid2 = 0; out_ready = 0;
    value1 = 0; count1 = 0; value2 = 0; count2 = 0;
    #2;
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1; rst = 0;

    // Two lanes in one cycle, free-running sink.
    out_ready = 1;
    start = byte_cnt;
    drive(1, 8'd5, 8'd3, 1, 8'hFE, 8'd1);
    check("t1_level2", level, 2);
    check("t1_first_byte", {out_valid, out_data}, {1'b1, 8'h05});
    repeat (4) begin @(posedge clk); #1; end
    check("t1_bytes4", byte_cnt - start, 4);
    check("t1_level0", level, 0);
    check("t1_overflow", overflow, 0);

    // Lane 2 alone, then lane 1 alone.
    drive(0, 8'd0, 8'd0, 1, 8'd7, 8'd9);
    drive(1, 8'd1, 8'd1, 0, 8'd0, 8'd0);
    wait_drain("t2_drain", 20);

    // Fill under back-pressure to level 15, then one dropped cycle.
    out_ready = 0;
    drive(1, 8'h80, 8'h00, 0, 8'd0, 8'd0);
    for (int k = 0; k < 7; k++)
      drive(1, 8'(8'h20 + 2*k), 8'(k), 1, 8'(8'h21 + 2*k), 8'(8'h40 + k));
    check("t3_level15", level, 15);
    check("t3_in_ready", in_ready, 0);
    check("t3_no_ovf_yet", overflow, 0);
    in_valid1 = 1; in_valid2 = 1; value1 = 8'hEE; value2 = 8'hDD;
    @(posedge clk); #1;
    in_valid1 = 0; in_valid2 = 0;
    check("t3_overflow", overflow, 1);
    check("t3_level_held", level, 15);
    start = byte_cnt;
    out_ready = 1;
    wait_drain("t3_drain", 60);
    check("t3_bytes30", byte_cnt - start, 30);
    check("t3_level0", level, 0);

    // Stall handling on a single pair.
    out_ready = 0;
    drive(1, 8'd10, 8'd4, 0, 8'd0, 8'd0);
    repeat (2) begin
      check("t4_hold_value", {out_valid, out_data}, {1'b1, 8'h0A});
      @(posedge clk); #1;
    end
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
    check("t4_count_byte", {out_valid, out_data}, {1'b1, 8'h04});
    check("t4_no_pop_on_value", level, 1);
    @(posedge clk); #1;
    check("t4_hold_count", out_data, 8'h04);
    out_ready = 1; @(posedge clk); #1;
    check("t4_popped", level, 0);
    check("t4_idle", out_valid, 0);

    // Reset between edges while in COUNT state with level 6.
    out_ready = 0;
    for (int k = 0; k < 3; k++) drive(1, 8'(8'h60 + k), 8'd1, 1, 8'(8'h70 + k), 8'd2);
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
    check("t5_level6", level, 6);
    check("t5_count_state", out_data, 8'd1);
    #2 rst = 1; #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_level", level, 0);
    check("t5_rst_overflow", overflow, 0);
    check("t5_rst_out_data", out_data, 0);
    #2 rst = 0;
    exp_q.delete();
    @(posedge clk); #1;
    out_ready = 1;
    drive(1, 8'd3, 8'd2, 0, 8'd0, 8'd0);
    wait_drain("t5_drain", 10);

    // Forty single pairs with a random sink, wrapping the pointers.
    start = byte_cnt;
    for (int k = 0; k < 40; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      while (!in_ready) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
      if (k % 2 == 0) drive(1, 8'($urandom), 8'($urandom), 0, 8'd0, 8'd0);
      else            drive(0, 8'd0, 8'd0, 1, 8'($urandom), 8'($urandom));
    end
    out_ready = 1;
    wait_drain("t6_drain", 200);
    check("t6_bytes80", byte_cnt - start, 80);
    check("t6_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
